stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control sequencer for the 4-digit stopwatch datapath (BCD digit counters plus 7-segment scan). It debounces the two board keys, runs the IDLE/RUN/PAUSE/LAP mode state machine, and produces the 1 Hz count-enable strobe. It also drives the clear pulse and the display-hold level that the datapath consumes. It replaces ad-hoc level-sampled key handling with edge-accurate, debounced control.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
TICK_HZ, 1, count-enable strobe rate; TICK_DIV = CLK_HZ/TICK_HZ, integer, ≥2
DEB_CYCLES, 1000000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz); ≥2

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
KEY  input  2  raw active-low keys, asynchronous to Clock; KEY[0]=start/stop, KEY[1]=reset/lap
tick_en  output  1  one-cycle strobe; datapath increments digit 1 when high
clear  output  1  one-cycle pulse; datapath zeroes all digits
hold  output  1  level; datapath freezes displayed digits (counting continues)
state  output  2  0=IDLE, 1=RUN, 2=PAUSE, 3=LAP
LED  output  5  LED[3:0] one-hot state (bit n = state n); LED[4] toggles on every tick_en

Behaviour:
- Reset (sampled high on an edge): state=IDLE; tick_en=0; clear=0; hold=0; LED=5'b00001; prescaler=0; sync flops, debounced levels and prev-levels=1 (released); debounce counters=0. Reset mid-debounce or mid-tick discards the partial count.
- Sync: each KEY bit passes through 2 flops, then the debouncer.
- Debounce, per key: the counter increments while sync2 != deb and clears when they are equal. When the counter is at DEB_CYCLES-1 and the inputs still differ, deb <= sync2 and the counter clears. Any glitch shorter than DEB_CYCLES is ignored.
- Press event = deb_prev & ~deb, a one-cycle falling edge. Release generates no event.
- Latency: with KEY held low from sampling edge 1, deb falls at edge DEB_CYCLES+2, press is high during the following cycle, and state changes at edge DEB_CYCLES+3.
- FSM transitions (S = start press, R = reset press):
  IDLE: S -> RUN. R -> IDLE with clear pulse.
  RUN: S -> PAUSE. R -> LAP.
  LAP: S -> PAUSE, hold drops. R -> RUN.
  PAUSE: S -> RUN. R -> IDLE with clear pulse.
- Simultaneous S and R in the same cycle: S is taken and R is discarded.
- clear is registered and high for exactly the cycle after the PAUSE->IDLE or IDLE->IDLE transition edge. It never coincides with tick_en.
- hold is registered, and is 1 iff state==LAP.
- Prescaler, width clog2(TICK_DIV):
  - In RUN or LAP it counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0, and tick_en is high the next cycle, for exactly one cycle.
  - In PAUSE it holds its value, so the sub-second fraction is preserved and tick_en=0.
  - In IDLE it is forced to 0.
- Tick period is exactly TICK_DIV cycles while running. There is no tick on the RUN->PAUSE edge itself.
- LED[4] is a toggle flop, flipped when tick_en=1, and reset to 0.
- All outputs are registered; there are no combinational paths from KEY to any output.

Test Plan:
(Sim parameters for all scenarios: DEB_CYCLES=4, TICK_DIV=10.)
1. Reset, then KEY[0] low for 10 cycles -> state 0->1 exactly 7 edges after the first low sample. First tick_en 10 cycles after RUN entry, then every 10 cycles. LED[4] toggles on each tick.
2. KEY[0] glitch low for 3 cycles, then high -> no state change. Glitch low for 4 cycles -> RUN.
3. RUN -> press S at prescaler=6 -> PAUSE, no tick_en. Hold 50 cycles, press S -> RUN, and the first tick_en arrives 3 cycles after resume.
4. RUN, press R -> state=3, hold=1, tick_en keeps pulsing every 10 cycles. Press R -> state=1, hold=0. Press R then S -> PAUSE, hold=0.
5. PAUSE, press R -> state=0, clear=1 for exactly one cycle, prescaler=0. In IDLE, press R -> a one-cycle clear again, state stays 0.
6. Both keys debounced-pressed in the same cycle from RUN -> PAUSE, not LAP. Reset asserted mid-debounce (counter=2) -> all outputs return to reset values, and key release after Reset produces no event.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: key sync/debounce, IDLE/RUN/PAUSE/LAP mode FSM,
// count-enable prescaler, and the clear/hold/LED outputs for the BCD datapath.
module stopwatch_ctrl #(
    parameter int CLK_HZ     = 50000000,
    parameter int TICK_HZ    = 1,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] KEY,
    output logic       tick_en,
    output logic       clear,
    output logic       hold,
    output logic [1:0] state,
    output logic [4:0] LED
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = $clog2(TICK_DIV);
    localparam int DW       = $clog2(DEB_CYCLES);
    localparam logic [PW-1:0] P_MAX   = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    logic [1:0]    r_sync1, r_sync2, r_deb, r_deb_prev;
    logic [DW-1:0] r_cnt [2];
    logic          w_press_s, w_press_r, w_running, w_clr;
    state_t        r_state, w_next;
    logic [PW-1:0] r_presc;
    logic          r_tick, r_clear, r_hold;
    logic [4:0]    r_led;

    // Keys idle high (released); a level is accepted only after DEB_CYCLES
    // consecutive cycles of disagreement with the current debounced level.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_sync1    <= 2'b11;
            r_sync2    <= 2'b11;
            r_deb      <= 2'b11;
            r_deb_prev <= 2'b11;
            for (int k = 0; k < 2; k++) r_cnt[k] <= '0;
        end else begin
            r_sync1    <= KEY;
            r_sync2    <= r_sync1;
            r_deb_prev <= r_deb;
            for (int k = 0; k < 2; k++) begin
                if (r_sync2[k] == r_deb[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == DEB_MAX) begin
                    r_deb[k] <= r_sync2[k];
                    r_cnt[k] <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign w_press_s = r_deb_prev[0] & ~r_deb[0];
    assign w_press_r = r_deb_prev[1] & ~r_deb[1];
    assign w_running = (r_state == S_RUN) || (r_state == S_LAP);

    // Start press wins over a simultaneous reset/lap press.
    always_comb begin
        w_next = r_state;
        w_clr  = 1'b0;
        case (r_state)
            S_IDLE:  if (w_press_s) w_next = S_RUN;
                     else if (w_press_r) w_clr = 1'b1;
            S_RUN:   if (w_press_s) w_next = S_PAUSE;
                     else if (w_press_r) w_next = S_LAP;
            S_LAP:   if (w_press_s) w_next = S_PAUSE;
                     else if (w_press_r) w_next = S_RUN;
            S_PAUSE: if (w_press_s) w_next = S_RUN;
                     else if (w_press_r) begin
                         w_next = S_IDLE;
                         w_clr  = 1'b1;
                     end
            default: w_next = S_IDLE;
        endcase
    end

    // When leaving for PAUSE, w_press_s is necessarily the cause; a wrap that
    // would coincide with that edge is held at P_MAX so the second is not lost.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_tick  <= 1'b0;
            r_clear <= 1'b0;
            r_hold  <= 1'b0;
            r_led   <= 5'b00001;
            r_presc <= '0;
        end else begin
            r_state    <= w_next;
            r_clear    <= w_clr;
            r_hold     <= (w_next == S_LAP);
            r_led[3:0] <= 4'b0001 << w_next;
            r_led[4]   <= r_led[4] ^ r_tick;
            r_tick     <= w_running && (r_presc == P_MAX) && !w_press_s;
            if (r_state == S_IDLE || w_next == S_IDLE) begin
                r_presc <= '0;
            end else if (w_running) begin
                if (r_presc == P_MAX) r_presc <= w_press_s ? P_MAX : '0;
                else                  r_presc <= r_presc + 1'b1;
            end
        end
    end

    assign tick_en = r_tick;
    assign clear   = r_clear;
    assign hold    = r_hold;
    assign state   = r_state;
    assign LED     = r_led;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: windowed-history reference model compared every
// cycle, directed timing checks with literal expectations, then random keys.
module tb_stopwatch_ctrl;
  localparam int DEB = 4;
  localparam int DIV = 10;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] KEY = 2'b11;
  logic       tick_en, clear, hold;
  logic [1:0] state;
  logic [4:0] LED;

  int n_checks = 0;
  int n_pass = 0;

  stopwatch_ctrl #(.CLK_HZ(DIV), .TICK_HZ(1), .DEB_CYCLES(DEB)) dut (
    .Clock(Clock), .Reset(Reset), .KEY(KEY), .tick_en(tick_en),
    .clear(clear), .hold(hold), .state(state), .LED(LED)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a key level is accepted when the last DEB synchronised
  // samples all disagree with the accepted level; mode table; phase counter.
  logic [DEB:0] m_hist [2];
  logic [1:0]   m_deb, m_deb_prev;
  int           m_mode, m_phase;
  logic         m_tick, m_clear, m_led4, m_valid = 1'b0;

  always @(posedge Clock) begin
    if (Reset) begin
      m_hist[0] = '1; m_hist[1] = '1;
      m_deb = 2'b11; m_deb_prev = 2'b11;
      m_mode = 0; m_phase = 0;
      m_tick = 0; m_clear = 0; m_led4 = 0; m_valid = 1;
    end else begin
      logic ps, pr, run, flip;
      logic [1:0] nd;
      int nm;
      ps = m_deb_prev[0] & ~m_deb[0];
      pr = m_deb_prev[1] & ~m_deb[1];
      for (int k = 0; k < 2; k++) begin
        flip = 1;
        for (int j = 1; j <= DEB; j++) if (m_hist[k][j] == m_deb[k]) flip = 0;
        nd[k] = flip ? ~m_deb[k] : m_deb[k];
        m_hist[k] = {m_hist[k][DEB-1:0], KEY[k]};
      end
      m_deb_prev = m_deb;
      m_deb = nd;
      run = (m_mode == 1) || (m_mode == 3);
      nm = m_mode;
      m_clear = 0;
      if (ps) nm = (m_mode == 2 || m_mode == 0) ? 1 : 2;
      else if (pr) begin
        case (m_mode)
          0: m_clear = 1;
          1: nm = 3;
          3: nm = 1;
          default: begin nm = 0; m_clear = 1; end
        endcase
      end
      m_led4 = m_led4 ^ m_tick;
      m_tick = run && (m_phase == DIV - 1) && !ps;
      if (m_mode == 0 || nm == 0) m_phase = 0;
      else if (run) m_phase = (m_phase == DIV - 1) ? (ps ? DIV - 1 : 0) : m_phase + 1;
      m_mode = nm;
    end
  end

  always @(negedge Clock) begin
    if (m_valid) begin
      logic [9:0] exp_v;
      exp_v = {m_mode[1:0], (m_mode == 3), m_clear, m_tick, m_led4, 4'(4'b0001 << m_mode)};
      check("model_cycle", {22'd0, state, hold, clear, tick_en, LED}, {22'd0, exp_v});
    end
  end

  task automatic press(input int k, input int len);
    KEY[k] = 1'b0;
    repeat (len) @(negedge Clock);
    KEY[k] = 1'b1;
    repeat (12) @(negedge Clock);
  endtask

  task automatic wait_tick(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge Clock);
      if (tick_en && n < 0) n = i;
      if (n >= 0) break;
    end
  endtask

  // Press KEY[k] for len cycles; report first edge with state==s and first tick.
  task automatic timed_press(input int k, input int len, input int s, input int max,
                             output int n_state, output int n_tick, output int n_ticks);
    n_state = -1; n_tick = -1; n_ticks = 0;
    KEY[k] = 1'b0;
    for (int i = 1; i <= max; i++) begin
      @(negedge Clock);
      if (i == len) KEY[k] = 1'b1;
      if (state == 2'(s) && n_state < 0) n_state = i;
      if (tick_en) begin
        n_ticks++;
        if (n_tick < 0) n_tick = i;
      end
    end
  endtask

  initial begin
    int a, b, c, t, cl, ci, bad;
    repeat (3) @(negedge Clock);
    check("reset_outputs", {22'd0, state, hold, clear, tick_en, LED}, {22'd0, 10'b00_0_0_0_00001});
    Reset = 1'b0;
    @(negedge Clock);

    press(0, 3);
    check("glitch3_ignored", 32'(state), 32'd0);

    // Start press: RUN entry 7 edges after first low sample, ticks every 10.
    a = -1; b = -1; c = -1; t = 0;
    KEY[0] = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge Clock);
      if (i == 10) KEY[0] = 1'b1;
      if (state == 2'd1 && a < 0) a = i;
      if (tick_en) begin
        if (b < 0) b = i; else if (c < 0) c = i;
      end
      if (b > 0 && i == b + 1) t = t + (LED[4] ? 1 : 0);
      if (c > 0 && i == c + 1) t = t + (LED[4] ? 0 : 2);
    end
    check("run_entry_edge", a, 7);
    check("first_tick_gap", b - a, 10);
    check("tick_period", c - b, 10);
    check("led4_toggles", t, 3);

    // Pause at prescaler 6, no tick while paused, resume 3 cycles to tick.
    wait_tick(20, a);
    timed_press(0, 4, 2, 15, a, b, c);
    check("pause_entry_edge", a, 7);
    check("pause_no_tick", c, 0);
    c = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clock);
      if (tick_en || state != 2'd2) c++;
    end
    check("pause_held", c, 0);
    timed_press(0, 4, 1, 20, a, b, c);
    check("resume_entry_edge", a, 7);
    check("resume_tick_gap", b - a, 3);
    repeat (10) @(negedge Clock);

    // Lap mode.
    press(1, 5);
    check("lap_state_hold", {29'd0, state, hold}, {29'd0, 2'd3, 1'b1});
    wait_tick(20, a);
    wait_tick(20, b);
    check("lap_tick_period", (a < 0) ? -1 : b, 10);
    press(1, 5);
    check("lap_to_run", {29'd0, state, hold}, {29'd0, 2'd1, 1'b0});
    press(1, 5);
    press(0, 5);
    check("lap_to_pause", {29'd0, state, hold}, {29'd0, 2'd2, 1'b0});

    // Clear pulses from PAUSE and from IDLE.
    for (int r = 0; r < 2; r++) begin
      cl = 0; ci = -1; bad = 0;
      KEY[1] = 1'b0;
      for (int i = 1; i <= 16; i++) begin
        @(negedge Clock);
        if (i == 5) KEY[1] = 1'b1;
        if (clear) begin
          cl++;
          if (ci < 0) ci = i;
          if (state != 2'd0 || tick_en) bad++;
        end
      end
      check(r == 0 ? "clear_from_pause_edge" : "clear_from_idle_edge", ci, 7);
      check("clear_single_cycle", cl, 1);
      check("clear_state_idle", bad, 0);
      repeat (8) @(negedge Clock);
    end
    timed_press(0, 5, 1, 30, a, b, c);
    check("idle_prescaler_zero", b - a, 10);
    repeat (8) @(negedge Clock);

    // Simultaneous presses from RUN: start wins.
    KEY = 2'b00;
    repeat (5) @(negedge Clock);
    KEY = 2'b11;
    repeat (12) @(negedge Clock);
    check("both_keys_pause", {29'd0, state, hold}, {29'd0, 2'd2, 1'b0});

    // Reset while a press is mid-debounce.
    KEY[0] = 1'b0;
    repeat (4) @(negedge Clock);
    Reset = 1'b1;
    KEY[0] = 1'b1;
    @(negedge Clock);
    check("reset_mid_debounce", {22'd0, state, hold, clear, tick_en, LED}, {22'd0, 10'b00_0_0_0_00001});
    Reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (state != 2'd0 || clear) bad++;
    end
    check("no_event_after_reset", bad, 0);

    // Random key activity with occasional resets.
    a = 0; b = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge Clock);
      if (a == 0) begin KEY[0] = 1'($urandom_range(0, 1)); a = $urandom_range(1, 12); end
      if (b == 0) begin KEY[1] = 1'($urandom_range(0, 1)); b = $urandom_range(1, 12); end
      a--; b--;
      Reset = ($urandom_range(0, 499) == 0);
    end
    Reset = 1'b0;
    KEY = 2'b11;
    repeat (5) @(negedge Clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
